// File: rtl/blinker_tick_gen.sv
// Tick generator for the blinker toggle register: a programmable-rate enable
// pulse plus a debounced push-button that steps through four rates.
module blinker_tick_gen #(
    parameter int CNT_W        = 16,
    parameter int PERIOD0      = 1000,
    parameter int PERIOD1      = 500,
    parameter int PERIOD2      = 250,
    parameter int PERIOD3      = 100,
    parameter int DEBOUNCE_CYC = 20
) (
    input  logic       system1000,
    input  logic       system1000_rst,
    input  logic       en_i,
    input  logic       btn_i,
    output logic       tick_o,
    output logic [1:0] rate_o,
    output logic       press_o
);

    localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_CHK,
        HELD,
        REL_CHK
    } db_state_t;

    logic             sync1_reg;
    logic             sync2_reg;
    logic             btn_s;
    db_state_t        state_reg;
    db_state_t        state_next;
    logic [DB_W-1:0]  db_cnt_reg;
    logic [DB_W-1:0]  db_cnt_next;
    logic             press_event;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cur_last;
    logic [CNT_W-1:0] period_last [4];
    logic             tick_reg;
    logic             press_reg;
    logic [1:0]       rate_reg;

    // Terminal count per rate; a zero period behaves like a period of one.
    for (genvar gi = 0; gi < 4; gi++) begin : g_period
        localparam int P_RAW  = (gi == 0) ? PERIOD0 :
                                (gi == 1) ? PERIOD1 :
                                (gi == 2) ? PERIOD2 : PERIOD3;
        localparam int P_LAST = (P_RAW <= 0) ? 0 : P_RAW - 1;
        assign period_last[gi] = CNT_W'(P_LAST);
    end

    assign cur_last = period_last[rate_reg];
    assign btn_s    = sync2_reg;

    always_ff @(posedge system1000) begin
        if (system1000_rst) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
        end else begin
            sync1_reg <= btn_i;
            sync2_reg <= sync1_reg;
        end
    end

    always_ff @(posedge system1000) begin
        if (system1000_rst) begin
            state_reg  <= IDLE;
            db_cnt_reg <= '0;
        end else begin
            state_reg  <= state_next;
            db_cnt_reg <= db_cnt_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        db_cnt_next = db_cnt_reg;
        press_event = 1'b0;
        case (state_reg)
            IDLE: begin
                if (btn_s) begin
                    state_next  = PRESS_CHK;
                    db_cnt_next = DB_W'(1);
                end
            end
            PRESS_CHK: begin
                if (!btn_s) begin
                    state_next  = IDLE;
                    db_cnt_next = '0;
                end else if (db_cnt_reg == DB_LAST) begin
                    state_next  = HELD;
                    press_event = 1'b1;
                end else begin
                    db_cnt_next = db_cnt_reg + DB_W'(1);
                end
            end
            HELD: begin
                if (!btn_s) begin
                    state_next  = REL_CHK;
                    db_cnt_next = DB_W'(1);
                end
            end
            REL_CHK: begin
                if (btn_s) begin
                    state_next = HELD;
                end else if (db_cnt_reg == DB_LAST) begin
                    state_next  = IDLE;
                    db_cnt_next = '0;
                end else begin
                    db_cnt_next = db_cnt_reg + DB_W'(1);
                end
            end
            default: begin
                state_next  = IDLE;
                db_cnt_next = '0;
            end
        endcase
    end

    // A press restarts the period with the new rate and swallows any tick due now.
    always_ff @(posedge system1000) begin
        if (system1000_rst) begin
            cnt_reg   <= '0;
            tick_reg  <= 1'b0;
            press_reg <= 1'b0;
            rate_reg  <= 2'd0;
        end else begin
            press_reg <= press_event;
            if (press_event) begin
                rate_reg <= rate_reg + 2'd1;
                cnt_reg  <= '0;
                tick_reg <= 1'b0;
            end else if (en_i) begin
                if (cnt_reg == cur_last) begin
                    cnt_reg  <= '0;
                    tick_reg <= 1'b1;
                end else begin
                    cnt_reg  <= cnt_reg + CNT_W'(1);
                    tick_reg <= 1'b0;
                end
            end else begin
                tick_reg <= 1'b0;
            end
        end
    end

    assign tick_o  = tick_reg;
    assign press_o = press_reg;
    assign rate_o  = rate_reg;

endmodule

// File: tb/tb_blinker_tick_gen.sv
// Directed bench for blinker_tick_gen with short periods (4,3,2,1) and a
// three-sample debounce so every expected edge can be counted by hand.
module tb_blinker_tick_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       btn;
    logic       tick;
    logic       press;
    logic [1:0] rate;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    blinker_tick_gen #(
        .CNT_W       (8),
        .PERIOD0     (4),
        .PERIOD1     (3),
        .PERIOD2     (2),
        .PERIOD3     (1),
        .DEBOUNCE_CYC(3)
    ) dut (
        .system1000    (clk),
        .system1000_rst(rst),
        .en_i          (en),
        .btn_i         (btn),
        .tick_o        (tick),
        .rate_o        (rate),
        .press_o       (press)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Holds the button until press_o shows (bounded), then releases it fully.
    task automatic do_press(input logic [1:0] exp_rate, input string tag);
        int lat;
        lat = 0;
        btn = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step();
            if (press) begin
                lat = i;
                break;
            end
        end
        check_val({tag, "_latency"}, lat, 5);
        check_val({tag, "_rate"}, {30'd0, rate}, {30'd0, exp_rate});
        step();
        check_val({tag, "_press_width"}, {31'd0, press}, 0);
        btn = 1'b0;
        repeat (8) step();
        $display("press %s: latency=%0d rate=%0d", tag, lat, rate);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        en  = 1'b1;
        btn = 1'b0;

        // Test 1: reset state and rate-0 tick spacing
        step();
        step();
        check_val("t1_rst_tick", {31'd0, tick}, 0);
        check_val("t1_rst_press", {31'd0, press}, 0);
        check_val("t1_rst_rate", {30'd0, rate}, 0);
        rst = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            step();
            check_val($sformatf("t1_tick_e%0d", e), {31'd0, tick}, (e % 4 == 0) ? 1 : 0);
        end

        // Test 2: en low freezes the count and suppresses ticks
        for (int e = 1; e <= 9; e++) begin
            en = (e <= 2 || e >= 8) ? 1'b1 : 1'b0;
            step();
            check_val($sformatf("t2_tick_e%0d", e), {31'd0, tick}, (e == 9) ? 1 : 0);
        end

        // Test 3: clean press, rate 0 -> 1, ticks every 3 from the press edge
        for (int e = 1; e <= 20; e++) begin
            btn = (e <= 10) ? 1'b1 : 1'b0;
            step();
            check_val($sformatf("t3_press_e%0d", e), {31'd0, press}, (e == 5) ? 1 : 0);
            check_val($sformatf("t3_tick_e%0d", e), {31'd0, tick},
                      ((e == 4) || (e > 5 && (e - 5) % 3 == 0)) ? 1 : 0);
        end
        check_val("t3_rate", {30'd0, rate}, 1);

        // Test 4: bounce then steady high; the press also drops a due tick
        for (int b = 1; b <= 12; b++) begin
            btn = (b <= 4) ? ((b % 2 == 1) ? 1'b1 : 1'b0) : 1'b1;
            step();
            check_val($sformatf("t4_press_b%0d", b), {31'd0, press}, (b == 9) ? 1 : 0);
            check_val($sformatf("t4_tick_b%0d", b), {31'd0, tick},
                      (b == 3 || b == 6 || b == 11) ? 1 : 0);
        end
        check_val("t4_rate", {30'd0, rate}, 2);
        btn = 1'b0;
        repeat (8) step();

        // Test 5: four presses from reset walk the rate 1,2,3,0
        do_reset();
        do_press(2'd1, "t5_p1");
        do_press(2'd2, "t5_p2");
        do_press(2'd3, "t5_p3");
        for (int e = 1; e <= 6; e++) begin
            step();
            check_val($sformatf("t5_rate3_tick_e%0d", e), {31'd0, tick}, 1);
        end
        en = 1'b0;
        step();
        check_val("t5_rate3_en_off", {31'd0, tick}, 0);
        do_press(2'd0, "t5_p4_en_off");
        check_val("t5_tick_en_off", {31'd0, tick}, 0);
        en = 1'b1;

        // Test 6a: press completes on the edge a rate-0 tick is due
        do_reset();
        for (int e = 1; e <= 11; e++) begin
            btn = (e >= 4) ? 1'b1 : 1'b0;
            step();
            check_val($sformatf("t6a_tick_e%0d", e), {31'd0, tick}, (e == 4 || e == 11) ? 1 : 0);
            check_val($sformatf("t6a_press_e%0d", e), {31'd0, press}, (e == 8) ? 1 : 0);
        end
        check_val("t6a_rate", {30'd0, rate}, 1);
        btn = 1'b0;
        repeat (8) step();

        // Test 6b: reset lands mid-PRESS_CHK, then a full-latency press
        btn = 1'b1;
        repeat (3) step();
        rst = 1'b1;
        step();
        check_val("t6b_rst_tick", {31'd0, tick}, 0);
        check_val("t6b_rst_press", {31'd0, press}, 0);
        check_val("t6b_rst_rate", {30'd0, rate}, 0);
        rst = 1'b0;
        do_press(2'd1, "t6b_after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
